// File: rtl/mining_sched_pkg.sv
// Shared definitions for the mining lane scheduler: FSM state encoding,
// lane-index width derivation and default sizing constants.
package mining_sched_pkg;

  localparam int DEF_LANES   = 3;
  localparam int DEF_NONCE_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT      = 3'd2,
    ST_REPORT    = 3'd3,
    ST_EXHAUSTED = 3'd4
  } sched_state_e;

  // Lane index width: clog2(lanes), never narrower than one bit.
  function automatic int lane_w_f(input int lanes);
    return (lanes <= 1) ? 1 : $clog2(lanes);
  endfunction

endpackage

// File: rtl/mining_lane_scheduler_if.sv
// Control/lane bus of the mining lane scheduler. The master side is the
// system control plus the lane result collectors; the slave side is the
// scheduler itself.
interface mining_lane_scheduler_if
  import mining_sched_pkg::*;
#(
  parameter int LANES   = DEF_LANES,
  parameter int NONCE_W = DEF_NONCE_W
);
  localparam int LANE_W = lane_w_f(LANES);

  logic                       start;
  logic [LANES-1:0]           lane_valid;
  logic [LANES-1:0]           lane_hit;
  logic [LANES*NONCE_W-1:0]   lane_nonce;
  logic                       next;
  logic                       busy;
  logic                       finished;
  logic                       exhausted;
  logic [NONCE_W-1:0]         nonce_out;
  logic [LANE_W-1:0]          hit_lane;

  modport master (
    output start, lane_valid, lane_hit,
    input  lane_nonce, next, busy, finished, exhausted, nonce_out, hit_lane
  );

  modport slave (
    input  start, lane_valid, lane_hit,
    output lane_nonce, next, busy, finished, exhausted, nonce_out, hit_lane
  );
endinterface

// File: rtl/lane_winner_arb.sv
// Combinational winner selection among the recorded hit lanes.
// MINING_SCHED_RR_ARB_EN selects round-robin from a priority pointer;
// otherwise the lowest-index hit lane wins and the pointer is ignored.
module lane_winner_arb
  import mining_sched_pkg::*;
#(
  parameter  int LANES  = DEF_LANES,
  localparam int LANE_W = lane_w_f(LANES)
) (
  input  logic [LANES-1:0]  hits_i,
  input  logic [LANE_W-1:0] ptr_i,
  output logic [LANE_W-1:0] winner_o,
  output logic              any_o
);

`ifdef MINING_SCHED_RR_ARB_EN
  int idx_s;

  // Scan downward so the first hit at or after the pointer (with wrap) is kept last.
  always_comb begin
    winner_o = '0;
    any_o    = |hits_i;
    idx_s    = 0;
    for (int k = LANES - 1; k >= 0; k--) begin
      idx_s    = (int'(ptr_i) + k) % LANES;
      winner_o = hits_i[idx_s] ? LANE_W'(idx_s) : winner_o;
    end
  end
`else
  logic unused_ptr_s;
  assign unused_ptr_s = ^ptr_i;

  // Scan downward so the lowest-index hit lane is kept last.
  always_comb begin
    winner_o = '0;
    any_o    = |hits_i;
    for (int k = LANES - 1; k >= 0; k--) begin
      winner_o = hits_i[k] ? LANE_W'(k) : winner_o;
    end
  end
`endif

endmodule

// File: rtl/mining_lane_scheduler.sv
// Nonce-search sequencer: hands each lane a distinct nonce per group,
// collects completion/hit flags, arbitrates hits and reports the winner
// or exhaustion of the nonce space.
// Optional feature: define MINING_SCHED_RR_ARB_EN for round-robin
// arbitration across searches (adds a priority pointer register).
module mining_lane_scheduler
  import mining_sched_pkg::*;
#(
  parameter int LANES   = DEF_LANES,
  parameter int NONCE_W = DEF_NONCE_W
) (
  input logic                    clk,
  input logic                    reset,
  mining_lane_scheduler_if.slave bus
);
  localparam int               LANE_W   = lane_w_f(LANES);
  localparam logic [LANES-1:0] ALL_DONE = '1;

  // Nonce vector for a group starting at b; lane values wrap modulo 2^NONCE_W.
  function automatic logic [LANES*NONCE_W-1:0] nonces_f(input logic [NONCE_W-1:0] b);
    logic [LANES*NONCE_W-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) begin
      v[i*NONCE_W +: NONCE_W] = b + NONCE_W'(i);
    end
    return v;
  endfunction

  // Lanes whose base+i does not fit in NONCE_W bits are out of range.
  function automatic logic [LANES-1:0] oor_f(input logic [NONCE_W-1:0] b);
    logic [LANES-1:0] m;
    logic [NONCE_W:0] s;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      s    = {1'b0, b} + (NONCE_W+1)'(i);
      m[i] = s[NONCE_W];
    end
    return m;
  endfunction

  sched_state_e              state_q;
  logic [NONCE_W-1:0]        base_q;
  logic [LANES-1:0]          done_q;
  logic [LANES-1:0]          hits_q;
  logic [LANES*NONCE_W-1:0]  lane_nonce_q;
  logic                      next_q;
  logic                      busy_q;
  logic                      finished_q;
  logic                      exhausted_q;
  logic [NONCE_W-1:0]        nonce_out_q;
  logic [LANE_W-1:0]         hit_lane_q;

  logic [LANES-1:0]          in_range_s;
  logic [LANES-1:0]          done_d;
  logic [LANES-1:0]          hits_d;
  logic [NONCE_W-1:0]        base_d;
  logic [NONCE_W-1:0]        nonce_win_d;
  logic [NONCE_W:0]          last_sum_s;
  logic                      last_group_s;
  logic [LANE_W-1:0]         winner_s;
  logic                      any_hit_s;
  logic [LANE_W-1:0]         ptr_s;

  // Mask updates for this WAIT cycle and group-resolution helpers.
  always_comb begin
    in_range_s   = ~oor_f(base_q);
    done_d       = done_q | bus.lane_valid;
    hits_d       = hits_q | (bus.lane_valid & bus.lane_hit & ~done_q & in_range_s);
    base_d       = base_q + NONCE_W'(LANES);
    last_sum_s   = {1'b0, base_q} + (NONCE_W+1)'(LANES - 1);
    last_group_s = (last_sum_s >= {1'b0, {NONCE_W{1'b1}}});
    nonce_win_d  = base_q + NONCE_W'(winner_s);
  end

  lane_winner_arb #(.LANES(LANES)) u_arb (
    .hits_i   (hits_d),
    .ptr_i    (ptr_s),
    .winner_o (winner_s),
    .any_o    (any_hit_s)
  );

`ifdef MINING_SCHED_RR_ARB_EN
  logic [LANE_W-1:0] ptr_q;

  // Priority pointer moves just past each reported winner; start leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if ((state_q == ST_WAIT) && (done_d == ALL_DONE) && any_hit_s) begin
      ptr_q <= (int'(winner_s) == LANES - 1) ? '0 : winner_s + LANE_W'(1);
    end else begin
      ptr_q <= ptr_q;
    end
  end

  assign ptr_s = ptr_q;
`else
  assign ptr_s = '0;
`endif

  // Main sequencer: state, masks, nonce issue and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      done_q       <= '0;
      hits_q       <= '0;
      lane_nonce_q <= '0;
      next_q       <= 1'b0;
      busy_q       <= 1'b0;
      finished_q   <= 1'b0;
      exhausted_q  <= 1'b0;
      nonce_out_q  <= '0;
      hit_lane_q   <= '0;
    end else begin
      next_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_REPORT, ST_EXHAUSTED: begin
          if (bus.start) begin
            state_q      <= ST_ISSUE;
            base_q       <= '0;
            done_q       <= '0;
            hits_q       <= '0;
            lane_nonce_q <= nonces_f('0);
            next_q       <= 1'b1;
            busy_q       <= 1'b1;
            finished_q   <= 1'b0;
            exhausted_q  <= 1'b0;
          end else begin
            state_q <= state_q;
          end
        end
        ST_ISSUE: begin
          // Out-of-range lanes never report, so count them as already done.
          done_q  <= ~in_range_s;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          done_q <= done_d;
          hits_q <= hits_d;
          if (done_d == ALL_DONE) begin
            if (any_hit_s) begin
              state_q     <= ST_REPORT;
              busy_q      <= 1'b0;
              finished_q  <= 1'b1;
              hit_lane_q  <= winner_s;
              nonce_out_q <= nonce_win_d;
            end else if (last_group_s) begin
              state_q     <= ST_EXHAUSTED;
              busy_q      <= 1'b0;
              exhausted_q <= 1'b1;
            end else begin
              state_q      <= ST_ISSUE;
              base_q       <= base_d;
              done_q       <= '0;
              hits_q       <= '0;
              lane_nonce_q <= nonces_f(base_d);
              next_q       <= 1'b1;
            end
          end else begin
            state_q <= ST_WAIT;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.lane_nonce = lane_nonce_q;
  assign bus.next       = next_q;
  assign bus.busy       = busy_q;
  assign bus.finished   = finished_q;
  assign bus.exhausted  = exhausted_q;
  assign bus.nonce_out  = nonce_out_q;
  assign bus.hit_lane   = hit_lane_q;

endmodule

// File: tb/tb_mining_lane_scheduler.sv
// Scoreboard bench for mining_lane_scheduler (LANES=3, NONCE_W=4).
// Stimulus pushes expected events (issue / finish / exhaust); a monitor
// pops and compares them whenever the DUT presents next, finished or
// exhausted.
module tb_mining_lane_scheduler;
  import mining_sched_pkg::*;

  localparam int LANES   = 3;
  localparam int NONCE_W = 4;
  localparam int LANE_W  = lane_w_f(LANES);
  localparam int K_ISSUE = 0;
  localparam int K_FIN   = 1;
  localparam int K_EXH   = 2;

  typedef struct {
    int                       kind;
    logic [LANES*NONCE_W-1:0] nonces;
    logic [NONCE_W-1:0]       nout;
    logic [LANE_W-1:0]        lane;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mining_lane_scheduler_if #(.LANES(LANES), .NONCE_W(NONCE_W)) bus ();

  mining_lane_scheduler #(.LANES(LANES), .NONCE_W(NONCE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t expq[$];
  exp_t mon_e;
  int   tests_run = 0;
  int   failures  = 0;
  int   next_cnt  = 0;
  int   n0;
  logic fin_prev  = 1'b0;
  logic exh_prev  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [LANES*NONCE_W-1:0] mk(input int b);
    logic [LANES*NONCE_W-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) v[i*NONCE_W +: NONCE_W] = NONCE_W'(b + i);
    return v;
  endfunction

  task automatic push_issue(input int b);
    exp_t e;
    e.kind = K_ISSUE; e.nonces = mk(b); e.nout = '0; e.lane = '0;
    expq.push_back(e);
  endtask

  task automatic push_fin(input int n, input int l);
    exp_t e;
    e.kind = K_FIN; e.nonces = '0; e.nout = NONCE_W'(n); e.lane = LANE_W'(l);
    expq.push_back(e);
  endtask

  task automatic push_exh(input int b);
    exp_t e;
    e.kind = K_EXH; e.nonces = mk(b); e.nout = '0; e.lane = '0;
    expq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    push_issue(0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
  endtask

  task automatic pulse(input logic [LANES-1:0] v, input logic [LANES-1:0] h);
    bus.lane_valid = v;
    bus.lane_hit   = h;
    tick();
    bus.lane_valid = '0;
    bus.lane_hit   = '0;
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_status"}, 32'({bus.next, bus.busy, bus.finished, bus.exhausted}), 32'd0);
    check({tag, "_result"}, 32'({bus.nonce_out, bus.hit_lane}), 32'd0);
    check({tag, "_lane_nonce"}, 32'(bus.lane_nonce), 32'd0);
  endtask

  // Monitor: pop and compare an expectation on each DUT-presented event.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.next) begin
        next_cnt++;
        if (expq.size() == 0) begin
          tests_run++; failures++;
          $display("FAIL unexpected_next: got next=1 nonces=0x%0h, required no pulse", bus.lane_nonce);
        end else begin
          mon_e = expq.pop_front();
          check("issue_kind", 32'(K_ISSUE), 32'(mon_e.kind));
          check("issue_lane_nonce", 32'(bus.lane_nonce), 32'(mon_e.nonces));
        end
      end
      if (bus.finished && !fin_prev) begin
        if (expq.size() == 0) begin
          tests_run++; failures++;
          $display("FAIL unexpected_finished: got finished=1, required 0");
        end else begin
          mon_e = expq.pop_front();
          check("finish_kind", 32'(K_FIN), 32'(mon_e.kind));
          check("nonce_out", 32'(bus.nonce_out), 32'(mon_e.nout));
          check("hit_lane", 32'(bus.hit_lane), 32'(mon_e.lane));
        end
      end
      if (bus.exhausted && !exh_prev) begin
        if (expq.size() == 0) begin
          tests_run++; failures++;
          $display("FAIL unexpected_exhausted: got exhausted=1, required 0");
        end else begin
          mon_e = expq.pop_front();
          check("exhaust_kind", 32'(K_EXH), 32'(mon_e.kind));
          check("exhaust_lane_nonce", 32'(bus.lane_nonce), 32'(mon_e.nonces));
        end
      end
    end
    fin_prev = bus.finished;
    exh_prev = bus.exhausted;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.lane_valid = '0;
    bus.lane_hit = '0;
    repeat (2) tick();
    outputs_zero("reset");
    reset = 1'b0;
    tick();

    // Basic hit: lane 1 hits, valids on separate cycles.
    n0 = next_cnt;
    do_start();
    check("t1_busy_in_wait", 32'(bus.busy), 32'd1);
    pulse(3'b001, 3'b000);
    pulse(3'b010, 3'b010);
    push_fin(1, 1);
    pulse(3'b100, 3'b000);
    check("t1_finished", 32'(bus.finished), 32'd1);
    check("t1_busy_low", 32'(bus.busy), 32'd0);
    check("t1_next_once", 32'(next_cnt - n0), 32'd1);

    // Multi-group, staggered valids, duplicate valid, valid in ISSUE ignored.
    do_start();
    pulse(3'b001, 3'b000);
    pulse(3'b001, 3'b001);
    pulse(3'b010, 3'b000);
    push_issue(3);
    pulse(3'b100, 3'b000);
    pulse(3'b111, 3'b111);
    pulse(3'b100, 3'b000);
    pulse(3'b001, 3'b000);
    push_issue(6);
    pulse(3'b010, 3'b000);
    tick();
    pulse(3'b001, 3'b000);
    pulse(3'b010, 3'b000);
    push_fin(8, 2);
    pulse(3'b100, 3'b100);
    check("t2_finished", 32'(bus.finished), 32'd1);

    // Simultaneous hits on lanes 0 and 2, twice.
    do_start();
    pulse(3'b010, 3'b000);
    push_fin(0, 0);
    pulse(3'b101, 3'b101);
    do_start();
    pulse(3'b010, 3'b000);
`ifdef MINING_SCHED_RR_ARB_EN
    push_fin(2, 2);
`else
    push_fin(0, 0);
`endif
    pulse(3'b101, 3'b101);
    check("t3_finished", 32'(bus.finished), 32'd1);

    // Exhaustion: bases 0,3,...,15; last group lanes 1,2 out of range.
    do_start();
    for (int b = 0; b <= 12; b += 3) begin
      push_issue(b + 3);
      pulse(3'b111, 3'b000);
      tick();
    end
    pulse(3'b010, 3'b010);
    check("t4_oor_hit_ignored", 32'({bus.finished, bus.exhausted, bus.busy}), 32'd1);
    push_exh(15);
    pulse(3'b001, 3'b000);
    check("t4_exhausted", 32'(bus.exhausted), 32'd1);
    tick();
    check("t4_exhausted_sticky", 32'({bus.exhausted, bus.busy}), 32'd2);

    // Start while busy is ignored.
    do_start();
    pulse(3'b001, 3'b000);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t5_still_waiting", 32'({bus.busy, bus.finished}), 32'd2);
    pulse(3'b010, 3'b000);
    push_fin(2, 2);
    pulse(3'b100, 3'b100);
    check("t5_finished", 32'(bus.finished), 32'd1);

    // Reset mid-WAIT, then a clean restart.
    do_start();
    pulse(3'b001, 3'b000);
    pulse(3'b010, 3'b010);
    reset = 1'b1;
    tick();
    outputs_zero("t6_reset");
    reset = 1'b0;
    tick();
    do_start();
    pulse(3'b001, 3'b000);
    pulse(3'b010, 3'b000);
    push_fin(2, 2);
    pulse(3'b100, 3'b100);
    check("t6_finished", 32'(bus.finished), 32'd1);

    tick();
    check("queue_empty", 32'(expq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/mining_lane_scheduler.md
# mining_lane_scheduler

Sequencer for the parallel nonce-search datapath. It gives each hash lane a distinct nonce from a shared search space and issues one `next` pulse per group. It collects each lane's completion and hit flags, arbitrates simultaneous hits to a single winner, and reports `finished` with the winning nonce. If the nonce space runs out first, it reports `exhausted`. It sits between the top-level system control and the per-lane nonce/concatenate/hash/compare chains, and replaces free-running per-lane nonce stepping and the ad-hoc OR of lane results.

## Interface
Parameters:
- `LANES`, default 3: number of hash lanes, minimum 1.
- `NONCE_W`, default 32: nonce width.
- `LANE_W`, default `max(1, clog2(LANES))`: lane index width. Derived; not overridable.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: begins a new search. Sampled in IDLE, REPORT or EXHAUSTED. Ignored in ISSUE and WAIT.
- `lane_valid`, input, LANES: bit i pulses when lane i has compared the hash of its issued nonce.
- `lane_hit`, input, LANES: bit i means lane i's hash is at or below target. Qualified by `lane_valid[i]`.
- `lane_nonce`, output, LANES*NONCE_W: registered nonce for each lane. Lane i occupies bits [i*NONCE_W +: NONCE_W].
- `next`, output, 1: registered one-cycle pulse telling all lanes to hash `lane_nonce`.
- `busy`, output, 1: high in ISSUE and WAIT.
- `finished`, output, 1: high and held in REPORT.
- `exhausted`, output, 1: high and held in EXHAUSTED.
- `nonce_out`, output, NONCE_W: winning nonce. Valid while `finished` is high.
- `hit_lane`, output, LANE_W: index of the winning lane. Valid while `finished` is high.

## Operation
- FSM states: IDLE, ISSUE, WAIT, REPORT, EXHAUSTED.
- IDLE, REPORT or EXHAUSTED with `start` high:
  - `base` is set to 0.
  - The done mask and hit mask are cleared.
  - The FSM goes to ISSUE.
- ISSUE:
  - Lane i nonce is `(base + i) mod 2^NONCE_W`.
  - Lanes whose `base + i` (computed in NONCE_W+1 bits) exceeds 2^NONCE_W−1 are marked out-of-range. They are pre-set in the done mask, and their hits are never recorded.
  - `next` is 1 for this single cycle. The FSM then goes to WAIT.
- WAIT:
  - Each cycle, `done |= lane_valid` and `hits |= lane_valid & lane_hit & ~done & in_range`.
  - A repeat `lane_valid` from an already-done lane is ignored.
  - When the updated done mask is all ones, the group is resolved:
    - Any hit: latch the arbitration winner into `hit_lane`, latch its nonce into `nonce_out`, and go to REPORT.
    - No hit, and `base + LANES − 1` ≥ 2^NONCE_W−1: go to EXHAUSTED.
    - Otherwise: `base += LANES`, clear both masks, and go to ISSUE.
- Arbitration with no macro: the lowest-index hit lane wins.
- `lane_nonce` is held stable from ISSUE until the next ISSUE.
- REPORT and EXHAUSTED are sticky until `start` or `reset`.
- `reset` in any state, including mid-WAIT:
  - FSM goes to IDLE.
  - `base`, both masks, `next`, `busy`, `finished`, `exhausted`, `nonce_out`, `hit_lane` and `lane_nonce` all become 0.
  - Pending lane results are discarded.

## Timing
- `start` sampled at edge k: ISSUE during cycle k+1, so `next` is high in cycle k+1. WAIT begins at cycle k+2.
- `lane_valid` is accepted from the first WAIT cycle onward. `lane_valid` in the ISSUE cycle is ignored.
- The last `lane_valid` of a group at edge m gives one of:
  - ISSUE, with `next` high, in cycle m+1.
  - `finished`, `nonce_out` and `hit_lane` valid from cycle m+1.
  - `exhausted` high from cycle m+1.
- Lanes may complete in any order and on any cycles. All lanes completing in the same cycle resolves exactly like staggered completion.
- Minimum period per group is 2 cycles (ISSUE plus one WAIT cycle).

## Configuration
- `MINING_SCHED_RR_ARB_EN` defined: round-robin arbitration.
  - A LANE_W-bit priority pointer, reset to 0, selects the first hit lane at or after the pointer, with modular wrap.
  - On each entry to REPORT the pointer becomes `(winner + 1) mod LANES`.
  - `start` does not reset the pointer.
- `MINING_SCHED_RR_ARB_EN` undefined: fixed lowest-index priority, and no pointer register exists.

## Structure
- Shared package `mining_sched_pkg` contains:
  - the FSM state encoding;
  - the LANE_W derivation function;
  - the default LANES and NONCE_W constants.
- Sub-module `lane_winner_arb` is purely combinational: inputs are the hit mask and the pointer; outputs are the winner index and an any-hit flag. It contains both the fixed and round-robin variants, selected by `MINING_SCHED_RR_ARB_EN`.

## Test plan
- Basic hit (LANES=3):
  - Stimulus: `start`. Group 0 has `lane_valid` on lanes 0, 1, 2 on separate cycles, with only lane 1 hitting.
  - Required: `finished`=1, `nonce_out`=1, `hit_lane`=1, one cycle after the last valid. `next` pulsed exactly once.
- Multi-group with staggered valids:
  - Stimulus: no hits in groups 0 and 1; lane 2 hits in group 2.
  - Required: `lane_nonce` is {0,1,2}, then {3,4,5}, then {6,7,8}; `nonce_out`=8. A duplicate `lane_valid` inside a group changes nothing.
- Simultaneous hits:
  - Stimulus: lanes 0 and 2 hit in the same cycle of group 0, with a restart.
  - Required, fixed priority: `hit_lane`=0 on both searches.
  - Required, RR: first search 0, repeat search 2.
- Exhaustion (NONCE_W=4, LANES=3):
  - Stimulus: no hits.
  - Required: groups use bases 0, 3, …, 15; the last group has lanes 1 and 2 out-of-range. A hit on lane 1 in the last group is ignored. `exhausted`=1 after the lane-0 valid of base 15.
- Reset mid-WAIT:
  - Stimulus: `reset` pulsed after a partial set of `lane_valid`s.
  - Required: all outputs 0 the next cycle; a later `start` begins again at nonce 0.
- Start while busy:
  - Stimulus: `start` pulsed during WAIT.
  - Required: ignored; `base` and masks unchanged, no extra `next`.
